// File: rtl/hrm_control_unit_gen_pkg.sv
// HRM control unit: shared opcodes, state codes, strobe bundle.
// Strobe decode is a pure function of state (Moore outputs).
package hrm_control_unit_gen_pkg;

  localparam logic [3:0] OP_INBOX    = 4'h0;
  localparam logic [3:0] OP_OUTBOX   = 4'h1;
  localparam logic [3:0] OP_COPYFROM = 4'h2;
  localparam logic [3:0] OP_COPYTO   = 4'h3;
  localparam logic [3:0] OP_ADD      = 4'h4;
  localparam logic [3:0] OP_SUB      = 4'h5;
  localparam logic [3:0] OP_BUMPP    = 4'h6;
  localparam logic [3:0] OP_BUMPM    = 4'h7;
  localparam logic [3:0] OP_JUMP     = 4'h8;
  localparam logic [3:0] OP_JUMPZ    = 4'h9;
  localparam logic [3:0] OP_JUMPN    = 4'hA;
  localparam logic [3:0] OP_NOP0     = 4'hB;
  localparam logic [3:0] OP_NOP1     = 4'hC;
  localparam logic [3:0] OP_NOP2     = 4'hD;
  localparam logic [3:0] OP_SET      = 4'hE;
  localparam logic [3:0] OP_HALT     = 4'hF;

  localparam logic [1:0] HC_NONE = 2'b00;
  localparam logic [1:0] HC_HALT = 2'b01;
  localparam logic [1:0] HC_ILL  = 2'b10;
  localparam logic [1:0] HC_TMO  = 2'b11;

  localparam logic [1:0] MUX_IN  = 2'b00;
  localparam logic [1:0] MUX_MEM = 2'b01;
  localparam logic [1:0] MUX_IMM = 2'b10;
  localparam logic [1:0] MUX_ALU = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_INC = 3'b010;
  localparam logic [2:0] ALU_DEC = 3'b011;
  localparam logic [2:0] ALU_NEG = 3'b100;

  typedef enum logic [4:0] {
    S_RESET       = 5'b00000,
    S_FETCH_I     = 5'b00001,
    S_LOAD_IR     = 5'b00010,
    S_DECODE      = 5'b00011,
    S_INCPC2      = 5'b00100,
    S_FETCH_O     = 5'b00101,
    S_LOAD_AR     = 5'b00110,
    S_READMEM     = 5'b00111,
    S_READMEM2    = 5'b01000,
    S_LOAD_AR2    = 5'b01001,
    S_INBOX       = 5'b01010,
    S_OUTBOX      = 5'b01011,
    S_COPYFROM    = 5'b01100,
    S_COPYTO      = 5'b01101,
    S_ADD         = 5'b01110,
    S_SUB         = 5'b01111,
    S_BUMPP       = 5'b10000,
    S_BUMPM       = 5'b10001,
    S_JUMP        = 5'b10010,
    S_JUMPZ       = 5'b10011,
    S_JUMPN       = 5'b10100,
    S_INC_PC      = 5'b10101,
    S_WAIT_INBOX  = 5'b10110,
    S_WAIT_OUTBOX = 5'b10111,
    S_WAIT_KEY    = 5'b11000,
    S_HALT        = 5'b11001,
    S_BREAK       = 5'b11011,
    S_SET         = 5'b11100
  } state_t;

  typedef struct packed {
    logic       wIR;
    logic       wR;
    logic       srcA;
    logic       wM;
    logic       wAR;
    logic       wPC;
    logic       rIn;
    logic       wO;
    logic       ijump;
    logic       branch;
    logic       rst;
    logic       halt;
    logic       brk;
    logic [1:0] muxR;
    logic [2:0] aluCtl;
  } strobe_t;

  function automatic strobe_t state_strobes(state_t s);
    strobe_t o;
    o = '0;
    case (s)
      S_RESET:    o.rst = 1'b1;
      S_LOAD_IR:  o.wIR = 1'b1;
      S_INBOX:    begin o.rIn = 1'b1; o.wR = 1'b1; o.muxR = MUX_IN; end
      S_OUTBOX:   o.wO = 1'b1;
      S_COPYFROM: begin o.wR = 1'b1; o.muxR = MUX_MEM; end
      S_ADD:      begin o.wR = 1'b1; o.muxR = MUX_ALU; o.aluCtl = ALU_ADD; end
      S_SUB:      begin o.wR = 1'b1; o.muxR = MUX_ALU; o.aluCtl = ALU_SUB; end
      S_BUMPP:    begin o.wR = 1'b1; o.muxR = MUX_ALU; o.aluCtl = ALU_INC; end
      S_BUMPM:    begin o.wR = 1'b1; o.muxR = MUX_ALU; o.aluCtl = ALU_DEC; end
      S_SET:      begin o.wR = 1'b1; o.muxR = MUX_IMM; end
      S_COPYTO:   o.wM = 1'b1;
      S_INC_PC:   o.wPC = 1'b1;
      S_INCPC2:   o.wPC = 1'b1;
      S_JUMP:     begin o.branch = 1'b1; o.ijump = 1'b1; o.wPC = 1'b1; end
      S_JUMPZ:    begin o.branch = 1'b1; o.wPC = 1'b1; o.aluCtl = ALU_ADD; end
      S_JUMPN:    begin o.branch = 1'b1; o.wPC = 1'b1; o.aluCtl = ALU_NEG; end
      S_LOAD_AR:  o.wAR = 1'b1;
      S_LOAD_AR2: begin o.wAR = 1'b1; o.srcA = 1'b1; end
      S_HALT:     o.halt = 1'b1;
      S_BREAK:    o.brk = 1'b1;
      default:    ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/hrm_control_unit_gen_wait_timer.sv
// Wait-state timeout counter: cleared on wait entry, counts while waiting.
// expire flags the last allowed cycle; TIMEOUT=0 never expires.
module hrm_wait_timer #(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic i_rst,
  input  logic load,
  input  logic count,
  output logic expire
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] cnt;

  // Clear on entry, then advance once per waiting cycle.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) cnt <= '0;
    else if (load) cnt <= '0;
    else if (count) cnt <= cnt + TW'(1);
  end

  assign expire = (TIMEOUT != 0) && count
                  && (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/hrm_control_unit_gen.sv
// HRM CPU control FSM: decode, breakpoint, wait timeout, halt cause.
// Strobes are registered from the next state so they track state_o.
module hrm_control_unit_gen
  import hrm_control_unit_gen_pkg::*;
#(
  parameter int PC_W         = 8,
  parameter int CNT_W        = 16,
  parameter int WAIT_TIMEOUT = 0,
  parameter int EN_EXT       = 1
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [7:0]       INSTR,
  input  logic [PC_W-1:0]  PC,
  input  logic             inEmpty,
  input  logic             outFull,
  input  logic             debug,
  input  logic             nxtInstr,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             wIR,
  output logic             wR,
  output logic             srcA,
  output logic             wM,
  output logic             wAR,
  output logic             wPC,
  output logic             rIn,
  output logic             wO,
  output logic             ijump,
  output logic             branch,
  output logic             rst,
  output logic             halt,
  output logic [1:0]       muxR,
  output logic [2:0]       aluCtl,
  output logic             brk,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] instr_count,
  output logic [4:0]       state_o
);
  state_t     state, nxt;
  logic [1:0] nxt_cause;
  logic       bp_skip;
  strobe_t    sb;
  logic [3:0] op;
  logic       ind;
  logic       ext;
  logic       waiting, wait_load, expire;
  logic       unused_bits;

  assign op          = INSTR[7:4];
  assign ind         = INSTR[3];
  assign unused_bits = ^INSTR[2:0];
  assign ext         = (EN_EXT != 0);

  assign waiting   = (state == S_WAIT_INBOX)
                   | (state == S_WAIT_OUTBOX);
  assign wait_load = (nxt != state)
                   & ((nxt == S_WAIT_INBOX)
                   | (nxt == S_WAIT_OUTBOX));

  hrm_wait_timer #(.TIMEOUT(WAIT_TIMEOUT)) u_timer (
    .clk    (clk),
    .i_rst  (i_rst),
    .load   (wait_load),
    .count  (waiting),
    .expire (expire)
  );

  // Next-state and halt-cause selection.
  always_comb begin
    nxt       = state;
    nxt_cause = HC_NONE;
    case (state)
      S_RESET:   nxt = S_FETCH_I;
      S_FETCH_I: begin
        if (bp_en && PC == bp_addr && !bp_skip) nxt = S_BREAK;
        else if (debug) nxt = S_WAIT_KEY;
        else nxt = S_LOAD_IR;
      end
      S_BREAK, S_WAIT_KEY: if (nxtInstr) nxt = S_LOAD_IR;
      S_LOAD_IR: nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_INBOX:  nxt = inEmpty ? S_WAIT_INBOX : S_INBOX;
          OP_OUTBOX: nxt = outFull ? S_WAIT_OUTBOX : S_OUTBOX;
          OP_HALT: begin
            nxt = S_HALT;
            nxt_cause = HC_HALT;
          end
          OP_NOP0, OP_NOP1, OP_NOP2, OP_SET: begin
            if (!ext) begin
              nxt = S_HALT;
              nxt_cause = HC_ILL;
            end else begin
              nxt = (op == OP_SET) ? S_INCPC2 : S_INC_PC;
            end
          end
          default: nxt = S_INCPC2;
        endcase
      end
      S_INCPC2: nxt = S_FETCH_O;
      S_FETCH_O: begin
        case (op)
          OP_JUMP:  nxt = S_JUMP;
          OP_JUMPZ: nxt = S_JUMPZ;
          OP_JUMPN: nxt = S_JUMPN;
          OP_SET:   nxt = S_SET;
          default:  nxt = S_LOAD_AR;
        endcase
      end
      S_LOAD_AR: begin
        if (op == OP_COPYTO && !ind) nxt = S_COPYTO;
        else if (ind) nxt = S_READMEM2;
        else nxt = S_READMEM;
      end
      S_READMEM2: nxt = S_LOAD_AR2;
      S_LOAD_AR2: nxt = (op == OP_COPYTO) ? S_COPYTO : S_READMEM;
      S_READMEM: begin
        case (op)
          OP_ADD:      nxt = S_ADD;
          OP_SUB:      nxt = S_SUB;
          OP_BUMPP:    nxt = S_BUMPP;
          OP_BUMPM:    nxt = S_BUMPM;
          OP_COPYFROM: nxt = S_COPYFROM;
          default: begin
            nxt = S_HALT;
            nxt_cause = HC_ILL;
          end
        endcase
      end
      S_BUMPP, S_BUMPM: nxt = S_COPYTO;
      S_ADD, S_SUB, S_COPYFROM, S_COPYTO,
      S_INBOX, S_OUTBOX, S_SET: nxt = S_INC_PC;
      S_INC_PC: nxt = S_FETCH_I;
      S_JUMP, S_JUMPZ, S_JUMPN: nxt = S_FETCH_I;
      S_WAIT_INBOX: begin
        if (!inEmpty) nxt = S_INBOX;
        else if (expire) begin
          nxt = S_HALT;
          nxt_cause = HC_TMO;
        end
      end
      S_WAIT_OUTBOX: begin
        if (!outFull) nxt = S_OUTBOX;
        else if (expire) begin
          nxt = S_HALT;
          nxt_cause = HC_TMO;
        end
      end
      S_HALT: nxt = S_HALT;
      default: begin
        nxt = S_HALT;
        nxt_cause = HC_ILL;
      end
    endcase
  end

  // State, registered strobes, cause latch, skip flag, retire count.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_RESET;
      sb          <= state_strobes(S_RESET);
      halt_cause  <= HC_NONE;
      instr_count <= '0;
      bp_skip     <= 1'b0;
    end else begin
      state <= nxt;
      sb    <= state_strobes(nxt);
      if (nxt == S_HALT && state != S_HALT) halt_cause <= nxt_cause;
      if (nxt == S_LOAD_IR && state != S_LOAD_IR)
        bp_skip <= (state == S_BREAK);
      if (state inside {S_INC_PC, S_JUMP, S_JUMPZ, S_JUMPN})
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign wIR     = sb.wIR;
  assign wR      = sb.wR;
  assign srcA    = sb.srcA;
  assign wM      = sb.wM;
  assign wAR     = sb.wAR;
  assign wPC     = sb.wPC;
  assign rIn     = sb.rIn;
  assign wO      = sb.wO;
  assign ijump   = sb.ijump;
  assign branch  = sb.branch;
  assign rst     = sb.rst;
  assign halt    = sb.halt;
  assign brk     = sb.brk;
  assign muxR    = sb.muxR;
  assign aluCtl  = sb.aluCtl;
  assign state_o = state;

endmodule

// File: tb/tb_hrm_control_unit_gen.sv
// Bench for hrm_control_unit_gen: cycle tables and directed sequences.
// A second instance covers EN_EXT=0 and a disabled timeout.
module tb_hrm_control_unit_gen;
  import hrm_control_unit_gen_pkg::*;

  logic       clk, i_rst;
  logic [7:0] INSTR, PC, bp_addr;
  logic       inEmpty, outFull, debug, nxtInstr, bp_en;

  logic wIR, wR, srcA, wM, wAR, wPC, rIn, wO;
  logic ijump, branch, rst, halt, brk;
  logic [1:0] muxR, halt_cause;
  logic [2:0] aluCtl;
  logic [15:0] instr_count;
  logic [4:0] state_o;

  logic z_wIR, z_wR, z_srcA, z_wM, z_wAR, z_wPC, z_rIn, z_wO;
  logic z_ijump, z_branch, z_rst, z_halt, z_brk;
  logic [1:0] z_muxR, z_halt_cause;
  logic [2:0] z_aluCtl;
  logic [15:0] z_instr_count;
  logic [4:0] z_state_o;

  hrm_control_unit_gen #(
    .PC_W(8), .CNT_W(16), .WAIT_TIMEOUT(8), .EN_EXT(1)
  ) dut (
    .clk(clk), .i_rst(i_rst), .INSTR(INSTR), .PC(PC),
    .inEmpty(inEmpty), .outFull(outFull), .debug(debug),
    .nxtInstr(nxtInstr), .bp_en(bp_en), .bp_addr(bp_addr),
    .wIR(wIR), .wR(wR), .srcA(srcA), .wM(wM), .wAR(wAR),
    .wPC(wPC), .rIn(rIn), .wO(wO), .ijump(ijump),
    .branch(branch), .rst(rst), .halt(halt), .muxR(muxR),
    .aluCtl(aluCtl), .brk(brk), .halt_cause(halt_cause),
    .instr_count(instr_count), .state_o(state_o)
  );

  hrm_control_unit_gen #(
    .PC_W(8), .CNT_W(16), .WAIT_TIMEOUT(0), .EN_EXT(0)
  ) dut0 (
    .clk(clk), .i_rst(i_rst), .INSTR(INSTR), .PC(PC),
    .inEmpty(inEmpty), .outFull(outFull), .debug(debug),
    .nxtInstr(nxtInstr), .bp_en(bp_en), .bp_addr(bp_addr),
    .wIR(z_wIR), .wR(z_wR), .srcA(z_srcA), .wM(z_wM),
    .wAR(z_wAR), .wPC(z_wPC), .rIn(z_rIn), .wO(z_wO),
    .ijump(z_ijump), .branch(z_branch), .rst(z_rst),
    .halt(z_halt), .muxR(z_muxR), .aluCtl(z_aluCtl),
    .brk(z_brk), .halt_cause(z_halt_cause),
    .instr_count(z_instr_count), .state_o(z_state_o)
  );

  typedef struct packed {
    logic wir, wr, srca, wm, war, wpc, rin, wo;
    logic ij, br, rs, hl, bk;
    logic [1:0] mx;
    logic [2:0] alu;
  } sb_t;

  typedef struct {
    logic [4:0] st;
    logic [7:0] ins;
    logic [7:0] pc;
    logic       ie;
  } vec_t;

  sb_t act_sb;
  assign act_sb = {wIR, wR, srcA, wM, wAR, wPC, rIn, wO,
                   ijump, branch, rst, halt, brk, muxR, aluCtl};

  int errors = 0;
  int checks = 0;
  vec_t p1[25];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic sb_t exp_sb(logic [4:0] st);
    sb_t e;
    e = '0;
    case (st)
      S_RESET:    e.rs = 1;
      S_LOAD_IR:  e.wir = 1;
      S_INBOX:    begin e.rin = 1; e.wr = 1; e.mx = 2'b00; end
      S_OUTBOX:   e.wo = 1;
      S_COPYFROM: begin e.wr = 1; e.mx = 2'b01; end
      S_ADD:      begin e.wr = 1; e.mx = 2'b11; e.alu = 3'b000; end
      S_SUB:      begin e.wr = 1; e.mx = 2'b11; e.alu = 3'b001; end
      S_BUMPP:    begin e.wr = 1; e.mx = 2'b11; e.alu = 3'b010; end
      S_BUMPM:    begin e.wr = 1; e.mx = 2'b11; e.alu = 3'b011; end
      S_SET:      begin e.wr = 1; e.mx = 2'b10; end
      S_COPYTO:   e.wm = 1;
      S_INC_PC:   e.wpc = 1;
      S_INCPC2:   e.wpc = 1;
      S_JUMP:     begin e.br = 1; e.ij = 1; e.wpc = 1; end
      S_JUMPZ:    begin e.br = 1; e.wpc = 1; end
      S_JUMPN:    begin e.br = 1; e.wpc = 1; e.alu = 3'b100; end
      S_LOAD_AR:  e.war = 1;
      S_LOAD_AR2: begin e.war = 1; e.srca = 1; end
      S_HALT:     e.hl = 1;
      S_BREAK:    e.bk = 1;
      default:    ;
    endcase
    return e;
  endfunction

  function automatic vec_t mk(logic [4:0] st, logic [7:0] ins,
                              logic [7:0] pc, logic ie);
    vec_t v;
    v.st = st; v.ins = ins; v.pc = pc; v.ie = ie;
    return v;
  endfunction

  task automatic chk_val(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_cur(string nm, logic [4:0] st);
    sb_t e;
    e = exp_sb(st);
    checks++;
    if (state_o !== st) begin
      errors++;
      $display("FAIL %s state: got %b expected %b", nm, state_o, st);
    end
    checks++;
    if (act_sb !== e) begin
      errors++;
      $display("FAIL %s strobes: got %h expected %h", nm, act_sb, e);
    end
  endtask

  task automatic step(string tag, logic [4:0] st, logic [7:0] ins,
                      logic [7:0] pc, logic ie, logic dbg, logic nx);
    chk_cur(tag, st);
    INSTR = ins; PC = pc; inEmpty = ie; debug = dbg; nxtInstr = nx;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1;
    nxtInstr = 0; debug = 0; inEmpty = 0; outFull = 0;
    #2;
    chk_cur("reset", S_RESET);
    chk_val("reset cause", int'(halt_cause), 0);
    chk_val("reset count", int'(instr_count), 0);
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; INSTR = 8'h00; PC = 8'h00;
    inEmpty = 0; outFull = 0; debug = 0; nxtInstr = 0;
    bp_en = 0; bp_addr = 8'h00;

    p1[0]  = mk(S_RESET,    8'h00, 8'd0, 0);
    p1[1]  = mk(S_FETCH_I,  8'h00, 8'd0, 0);
    p1[2]  = mk(S_LOAD_IR,  8'h00, 8'd0, 0);
    p1[3]  = mk(S_DECODE,   8'h00, 8'd0, 0);
    p1[4]  = mk(S_INBOX,    8'h00, 8'd0, 0);
    p1[5]  = mk(S_INC_PC,   8'h00, 8'd0, 0);
    p1[6]  = mk(S_FETCH_I,  8'h45, 8'd1, 0);
    p1[7]  = mk(S_LOAD_IR,  8'h45, 8'd1, 0);
    p1[8]  = mk(S_DECODE,   8'h45, 8'd1, 0);
    p1[9]  = mk(S_INCPC2,   8'h45, 8'd1, 0);
    p1[10] = mk(S_FETCH_O,  8'h45, 8'd2, 0);
    p1[11] = mk(S_LOAD_AR,  8'h45, 8'd2, 0);
    p1[12] = mk(S_READMEM,  8'h45, 8'd2, 0);
    p1[13] = mk(S_ADD,      8'h45, 8'd2, 0);
    p1[14] = mk(S_INC_PC,   8'h45, 8'd2, 0);
    p1[15] = mk(S_FETCH_I,  8'h10, 8'd3, 0);
    p1[16] = mk(S_LOAD_IR,  8'h10, 8'd3, 0);
    p1[17] = mk(S_DECODE,   8'h10, 8'd3, 0);
    p1[18] = mk(S_OUTBOX,   8'h10, 8'd3, 0);
    p1[19] = mk(S_INC_PC,   8'h10, 8'd3, 0);
    p1[20] = mk(S_FETCH_I,  8'hF0, 8'd4, 0);
    p1[21] = mk(S_LOAD_IR,  8'hF0, 8'd4, 0);
    p1[22] = mk(S_DECODE,   8'hF0, 8'd4, 0);
    p1[23] = mk(S_HALT,     8'hF0, 8'd4, 0);
    p1[24] = mk(S_HALT,     8'hF0, 8'd4, 0);

    // Program 1: INBOX, ADD 5, OUTBOX, HALT
    do_reset();
    for (int i = 0; i < 25; i++)
      step($sformatf("p1[%0d]", i), p1[i].st, p1[i].ins,
           p1[i].pc, p1[i].ie, 1'b0, 1'b0);
    chk_val("p1 cause", int'(halt_cause), 1);
    chk_val("p1 count", int'(instr_count), 3);

    // SET 0x2A then HALT; dut0 rejects SET
    do_reset();
    step("set0", S_RESET,   8'hE0, 8'd0, 0, 0, 0);
    step("set1", S_FETCH_I, 8'hE0, 8'd0, 0, 0, 0);
    step("set2", S_LOAD_IR, 8'hE0, 8'd0, 0, 0, 0);
    step("set3", S_DECODE,  8'hE0, 8'd0, 0, 0, 0);
    step("set4", S_INCPC2,  8'hE0, 8'd0, 0, 0, 0);
    step("set5", S_FETCH_O, 8'hE0, 8'd1, 0, 0, 0);
    step("set6", S_SET,     8'hE0, 8'd1, 0, 0, 0);
    step("set7", S_INC_PC,  8'hE0, 8'd1, 0, 0, 0);
    step("set8", S_FETCH_I, 8'hF0, 8'd2, 0, 0, 0);
    step("set9", S_LOAD_IR, 8'hF0, 8'd2, 0, 0, 0);
    step("setA", S_DECODE,  8'hF0, 8'd2, 0, 0, 0);
    step("setB", S_HALT,    8'hF0, 8'd2, 0, 0, 0);
    chk_val("set count", int'(instr_count), 1);
    chk_val("set cause", int'(halt_cause), 1);
    chk_val("ext0 state", int'(z_state_o), int'(S_HALT));
    chk_val("ext0 cause", int'(z_halt_cause), 2);
    chk_val("ext0 halt", int'(z_halt), 1);

    // Breakpoint at PC=4, resume, skip once, re-break, then debug key
    bp_en = 1; bp_addr = 8'd4;
    do_reset();
    step("bp0", S_RESET,    8'hB0, 8'd4, 0, 0, 0);
    step("bp1", S_FETCH_I,  8'hB0, 8'd4, 0, 0, 0);
    step("bp2", S_BREAK,    8'hB0, 8'd4, 0, 0, 0);
    step("bp3", S_BREAK,    8'hB0, 8'd4, 0, 0, 0);
    step("bp4", S_BREAK,    8'hB0, 8'd4, 0, 0, 1);
    step("bp5", S_LOAD_IR,  8'hB0, 8'd4, 0, 0, 0);
    step("bp6", S_DECODE,   8'hB0, 8'd4, 0, 0, 0);
    step("bp7", S_INC_PC,   8'hB0, 8'd4, 0, 0, 0);
    step("bp8", S_FETCH_I,  8'hB0, 8'd4, 0, 0, 0);
    step("bp9", S_LOAD_IR,  8'hB0, 8'd4, 0, 0, 0);
    step("bpA", S_DECODE,   8'hB0, 8'd4, 0, 0, 0);
    step("bpB", S_INC_PC,   8'hB0, 8'd4, 0, 0, 0);
    step("bpC", S_FETCH_I,  8'hB0, 8'd4, 0, 0, 0);
    step("bpD", S_BREAK,    8'hB0, 8'd4, 0, 0, 1);
    step("bpE", S_LOAD_IR,  8'hB0, 8'd4, 0, 0, 0);
    step("bpF", S_DECODE,   8'hB0, 8'd4, 0, 0, 0);
    step("bpG", S_INC_PC,   8'hB0, 8'd5, 0, 1, 0);
    step("bpH", S_FETCH_I,  8'hB0, 8'd5, 0, 1, 0);
    step("bpI", S_WAIT_KEY, 8'hB0, 8'd5, 0, 0, 0);
    step("bpJ", S_WAIT_KEY, 8'hB0, 8'd5, 0, 0, 1);
    step("bpK", S_LOAD_IR,  8'hB0, 8'd5, 0, 0, 0);
    chk_val("bp count", int'(instr_count), 3);
    bp_en = 0;

    // Timeout: inEmpty stuck high for 8 wait cycles
    do_reset();
    step("to0", S_RESET,   8'h00, 8'd0, 0, 0, 0);
    step("to1", S_FETCH_I, 8'h00, 8'd0, 0, 0, 0);
    step("to2", S_LOAD_IR, 8'h00, 8'd0, 1, 0, 0);
    step("to3", S_DECODE,  8'h00, 8'd0, 1, 0, 0);
    for (int k = 0; k < 8; k++)
      step($sformatf("tow%0d", k), S_WAIT_INBOX, 8'h00, 8'd0, 1, 0, 0);
    step("to4", S_HALT,    8'h00, 8'd0, 1, 0, 0);
    chk_val("to cause", int'(halt_cause), 3);
    chk_val("to0 nohalt", int'(z_state_o), int'(S_WAIT_INBOX));

    // Timeout race: data arrives on the last allowed cycle
    do_reset();
    step("tr0", S_RESET,   8'h00, 8'd0, 0, 0, 0);
    step("tr1", S_FETCH_I, 8'h00, 8'd0, 0, 0, 0);
    step("tr2", S_LOAD_IR, 8'h00, 8'd0, 1, 0, 0);
    step("tr3", S_DECODE,  8'h00, 8'd0, 1, 0, 0);
    for (int k = 0; k < 8; k++)
      step($sformatf("trw%0d", k), S_WAIT_INBOX, 8'h00, 8'd0,
           (k < 7) ? 1'b1 : 1'b0, 0, 0);
    step("tr4", S_INBOX,   8'h00, 8'd0, 0, 0, 0);
    step("tr5", S_INC_PC,  8'h00, 8'd0, 0, 0, 0);
    chk_val("tr cause", int'(halt_cause), 0);

    // Indirect COPYTO, full path
    do_reset();
    step("ci0", S_RESET,    8'h38, 8'd0, 0, 0, 0);
    step("ci1", S_FETCH_I,  8'h38, 8'd0, 0, 0, 0);
    step("ci2", S_LOAD_IR,  8'h38, 8'd0, 0, 0, 0);
    step("ci3", S_DECODE,   8'h38, 8'd0, 0, 0, 0);
    step("ci4", S_INCPC2,   8'h38, 8'd0, 0, 0, 0);
    step("ci5", S_FETCH_O,  8'h38, 8'd1, 0, 0, 0);
    step("ci6", S_LOAD_AR,  8'h38, 8'd1, 0, 0, 0);
    step("ci7", S_READMEM2, 8'h38, 8'd1, 0, 0, 0);
    step("ci8", S_LOAD_AR2, 8'h38, 8'd1, 0, 0, 0);
    step("ci9", S_COPYTO,   8'h38, 8'd1, 0, 0, 0);
    step("ciA", S_INC_PC,   8'h38, 8'd1, 0, 0, 0);
    step("ciB", S_FETCH_I,  8'h38, 8'd2, 0, 0, 0);

    // Same, aborted by reset while in LOAD_AR2
    do_reset();
    step("ca0", S_RESET,    8'h38, 8'd0, 0, 0, 0);
    step("ca1", S_FETCH_I,  8'h38, 8'd0, 0, 0, 0);
    step("ca2", S_LOAD_IR,  8'h38, 8'd0, 0, 0, 0);
    step("ca3", S_DECODE,   8'h38, 8'd0, 0, 0, 0);
    step("ca4", S_INCPC2,   8'h38, 8'd0, 0, 0, 0);
    step("ca5", S_FETCH_O,  8'h38, 8'd1, 0, 0, 0);
    step("ca6", S_LOAD_AR,  8'h38, 8'd1, 0, 0, 0);
    step("ca7", S_READMEM2, 8'h38, 8'd1, 0, 0, 0);
    chk_cur("ca8", S_LOAD_AR2);
    i_rst = 1'b1;
    #1;
    chk_cur("ca_abort", S_RESET);
    chk_val("ca count", int'(instr_count), 0);
    @(negedge clk);
    i_rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hrm_control_unit_gen.md
Name: hrm_control_unit_gen

Overview:
- Parametrised next-generation control FSM for the HRM CPU datapath: decodes 8-bit instructions and drives IR/R/AR/PC/memory/inbox/outbox strobes.
- Adds over the current generation:
  - SET-immediate and NOP opcodes
  - PC breakpoint with resume
  - wait-state timeout
  - halt-cause reporting
  - retired-instruction counter
- Sits between program memory/IR and the datapath; outputs are Moore (decoded from state only).

Parameters:
- PC_W, 8, width of PC and breakpoint address.
- CNT_W, 16, width of retired-instruction counter.
- WAIT_TIMEOUT, 0, max cycles in WAIT_INBOX/WAIT_OUTBOX before timeout halt; 0 disables.
- EN_EXT, 1, 1 enables SET (1110) and NOP (1011..1101); 0 makes them illegal.

Ports:
- clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- INSTR  in  8  [7:4] opcode, [3] indirect
- PC  in  PC_W  current program counter
- inEmpty, outFull  in  1  FIFO status
- debug  in  1  single-step mode
- nxtInstr  in  1  step/resume request (single-cycle pulse)
- bp_en  in  1  breakpoint enable
- bp_addr  in  PC_W  breakpoint address
- wIR, wR, srcA, wM, wAR, wPC, rIn, wO, ijump, branch, rst, halt  out  1  datapath strobes
- muxR  out  2  R source: 00 inbox, 01 mem, 10 immediate (operand), 11 ALU
- aluCtl  out  3  ALU op
- brk  out  1  stopped at breakpoint
- halt_cause  out  2  00 none, 01 HALT opcode, 10 illegal, 11 timeout
- instr_count  out  CNT_W  retired instructions
- state_o  out  5  state code, for debug display

Behaviour:
- Reset:
  - state=RESET, halt_cause=0, instr_count=0, timeout counter=0, bp_skip=0.
  - All strobes 0 except rst=1 while in RESET.
- Opcodes:
  - INBOX 0, OUTBOX 1, COPYFROM 2, COPYTO 3, ADD 4, SUB 5, BUMP+ 6, BUMP- 7, JUMP 8, JUMPZ 9, JUMPN A, NOP B-D, SET E, HALT F.
- Transitions:
  - RESET→FETCH_I; Inc_PC→FETCH_I.
  - FETCH_I, checks in priority order:
    - bp_en & PC==bp_addr & !bp_skip → BREAK
    - else debug → WAIT_KEY
    - else → LOAD_IR
  - BREAK: brk=1; nxtInstr → LOAD_IR and sets bp_skip.
  - WAIT_KEY: nxtInstr → LOAD_IR.
  - bp_skip clears on every entry to LOAD_IR that was not caused by BREAK.
  - LOAD_IR→DECODE.
  - DECODE:
    - INBOX → WAIT_INBOX if inEmpty, else INBOX.
    - OUTBOX → WAIT_OUTBOX if outFull, else OUTBOX.
    - HALT → HALT with cause 01.
    - NOP (EN_EXT) → Inc_PC.
    - NOP/SET with EN_EXT=0 → HALT with cause 10.
    - else → INCPC2.
  - INCPC2→FETCH_O.
  - FETCH_O:
    - JUMP, JUMPZ, JUMPN → their respective state.
    - SET → SET.
    - else → LOAD_AR.
  - LOAD_AR:
    - COPYTO & !indirect → COPYTO.
    - indirect → READMEM2→LOAD_AR2.
    - else → READMEM.
  - LOAD_AR2: COPYTO → COPYTO, else → READMEM.
  - READMEM:
    - ADD, SUB, BUMP+, BUMP-, COPYFROM → their states.
    - else → HALT with cause 10.
  - BUMP± → COPYTO.
  - ADD, SUB, COPYFROM, COPYTO, INBOX, OUTBOX, SET → Inc_PC.
  - JUMP* → FETCH_I.
  - Unused codes → HALT with cause 10.
- Strobes per state:
  - INBOX: rIn, wR, muxR=00.
  - OUTBOX: wO.
  - COPYFROM: wR, muxR=01.
  - ADD / SUB / BUMP+ / BUMP-: wR, muxR=11, aluCtl 000 / 001 / 010 / 011.
  - SET: wR, muxR=10.
  - COPYTO: wM.
  - Inc_PC, INCPC2: wPC.
  - JUMP: branch, ijump, wPC.
  - JUMPZ: branch, wPC, aluCtl=000.
  - JUMPN: branch, wPC, aluCtl=100.
  - LOAD_AR: wAR.
  - LOAD_AR2: wAR, srcA.
  - LOAD_IR: wIR.
  - HALT: halt.
- Timeout (WAIT_TIMEOUT>0):
  - Counter clears on entry to a WAIT state and increments each cycle spent there.
  - When the counter equals WAIT_TIMEOUT-1 and the condition is still unmet, next state is HALT with cause 11.
  - If the condition becomes true in that same cycle, resume wins.
- halt_cause latches on the cycle HALT is entered. HALT is terminal; only i_rst exits it.
- instr_count:
  - Increments by 1, wrapping, on each cycle in Inc_PC, JUMP, JUMPZ or JUMPN.
  - HALT opcode does not count.
- i_rst mid-operation: immediate return to RESET; no strobe from the aborted state is held.

Decomposition:
- Shared package holds:
  - opcode constants
  - 5-bit state encodings (existing codes kept; BREAK=11011, SET=11100)
  - halt_cause codes
  - muxR/aluCtl encodings
- Natural sub-module: hrm_wait_timer (load/count/expire) for the wait-timeout counter.

Test Plan:
- Program INBOX(00),ADD 5(45 05),OUTBOX(10),HALT(F0), inEmpty=0, outFull=0 → ADD passes through LOAD_AR, READMEM, ADD with wR=1, muxR=11, aluCtl=000; halt=1, halt_cause=01, instr_count=3.
- SET 0x2A (E0 2A) with EN_EXT=1 → SET state asserts wR, muxR=10 for exactly 1 cycle, then Inc_PC. Same program with EN_EXT=0 → halt_cause=10.
- bp_en=1, bp_addr=4, reach PC=4 → brk=1 and no wIR until nxtInstr pulse. After pulse, LOAD_IR once and no re-break at PC=4; returning to PC=4 later breaks again.
- WAIT_TIMEOUT=8, INBOX with inEmpty held 1 → halt entered 8 cycles after WAIT_INBOX entry, halt_cause=11. With inEmpty dropping on cycle 8 → INBOX, no halt.
- COPYTO indirect (38 03) → LOAD_AR, READMEM2, LOAD_AR2 (srcA=1, wAR=1), COPYTO (wM=1). Assert i_rst during LOAD_AR2 → state_o=00000 and rst=1 the same cycle, all other strobes 0.
